// File: rtl/tomasulo_pkg.sv
// Shared types and constants for the Tomasulo CDB: tag/word types, the CDB
// record and the execution-unit index map.
package tomasulo_pkg;

  localparam int N_EU      = 5;
  localparam int CDB_TAG_W = 3;
  localparam int CDB_W     = 32;

  localparam int ARITH_0 = 0;
  localparam int ARITH_1 = 1;
  localparam int LOGIC_0 = 2;
  localparam int LOGIC_1 = 3;
  localparam int MPY     = 4;

  typedef logic [CDB_TAG_W-1:0] tag_t;
  typedef logic [CDB_W-1:0]     word_t;

  typedef struct packed {
    logic  vld;
    tag_t  tag;
    word_t wdata;
  } cdb_t;

endpackage

// File: rtl/tomasulo_rr_arb.sv
// Round-robin arbiter: one-hot grant searching upward from ptr (mod N); the
// pointer moves just past the granted requester and holds when idle.
module tomasulo_rr_arb #(
  parameter int N = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req_i,
  output logic [N-1:0] gnt_o
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  logic [N-1:0]  mask_hi;
  logic [N-1:0]  req_hi;
  logic [N-1:0]  sel;

  // Requests at or above ptr win; otherwise wrap to the lowest requester.
  always_comb begin
    mask_hi = ~((N'(1) << ptr_q) - N'(1));
    req_hi  = req_i & mask_hi;
    sel     = (|req_hi) ? req_hi : req_i;
    gnt_o   = sel & (~sel + N'(1));
  end

  always_comb begin
    ptr_d = ptr_q;
    for (int j = 0; j < N; j++) begin
      if (gnt_o[j]) begin
        ptr_d = (j == N-1) ? '0 : PW'(j + 1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/tomasulo_cdb_arbiter.sv
// Common Data Bus arbiter: round-robin grant among the execution units, AND-OR
// result mux, and a registered CDB broadcast with a one-cycle-delayed busy flag.
module tomasulo_cdb_arbiter
  import tomasulo_pkg::*;
#(
  parameter int N     = N_EU,
  parameter int TAG_W = CDB_TAG_W,
  parameter int W     = CDB_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req_vld,
  input  logic [N*TAG_W-1:0] req_tag,
  input  logic [N*W-1:0] req_wdata,
  output logic [N-1:0]   req_ack,
  output cdb_t           cdb_r,
  output logic           busy_r
);

  logic [N-1:0]     req_gated;
  logic [N-1:0]     gnt;
  logic [TAG_W-1:0] tag_mux;
  logic [W-1:0]     wdata_mux;
  cdb_t             cdb_q, cdb_d;
  logic             busy_q;

  // No grants while reset is held, so the pointer cannot move either.
  assign req_gated = rst ? '0 : req_vld;

  tomasulo_rr_arb #(.N(N)) u_arb (
    .clk   (clk),
    .rst   (rst),
    .req_i (req_gated),
    .gnt_o (gnt)
  );

  assign req_ack = gnt;

  always_comb begin
    tag_mux   = '0;
    wdata_mux = '0;
    for (int i = 0; i < N; i++) begin
      tag_mux   = tag_mux   | (req_tag[i*TAG_W +: TAG_W] & {TAG_W{gnt[i]}});
      wdata_mux = wdata_mux | (req_wdata[i*W +: W]       & {W{gnt[i]}});
    end
  end

  // Tag and data hold their last broadcast value on idle cycles.
  always_comb begin
    cdb_d     = cdb_q;
    cdb_d.vld = |gnt;
    if (|gnt) begin
      cdb_d.tag   = tag_mux;
      cdb_d.wdata = wdata_mux;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cdb_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      cdb_q  <= cdb_d;
      busy_q <= cdb_q.vld;
    end
  end

  assign cdb_r  = cdb_q;
  assign busy_r = busy_q;

  a_ack_onehot : assert property (@(posedge clk) disable iff (rst) $onehot0(req_ack));
  a_ack_has_req : assert property (@(posedge clk) disable iff (rst) (req_ack & ~req_vld) == '0);

  for (genvar i = 0; i < N; i++) begin : g_chk
    logic [31:0] wait_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        wait_q <= '0;
      end else if (req_vld[i] && !req_ack[i]) begin
        wait_q <= wait_q + 32'd1;
      end else begin
        wait_q <= '0;
      end
    end

    a_hold : assert property (@(posedge clk) disable iff (rst)
      (req_vld[i] && !req_ack[i]) |=> (req_vld[i] &&
        $stable(req_tag[i*TAG_W +: TAG_W]) && $stable(req_wdata[i*W +: W])));

    a_fair : assert property (@(posedge clk) disable iff (rst) wait_q < 32'(N));
  end

endmodule

// File: tb/tb_tomasulo_cdb_arbiter.sv
// Bench for the CDB arbiter: round-robin reference model with a CDB scoreboard,
// a table of request/ack vectors, hand sequences and a long random run.
module tb_tomasulo_cdb_arbiter;
  import tomasulo_pkg::*;

  localparam int N  = N_EU;
  localparam int TW = CDB_TAG_W;
  localparam int WW = CDB_W;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_vld = '0;
  logic [N*TW-1:0] req_tag = '0;
  logic [N*WW-1:0] req_wdata = '0;
  logic [N-1:0]    req_ack;
  cdb_t            cdb_r;
  logic            busy_r;

  tomasulo_cdb_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req_vld   (req_vld),
    .req_tag   (req_tag),
    .req_wdata (req_wdata),
    .req_ack   (req_ack),
    .cdb_r     (cdb_r),
    .busy_r    (busy_r)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] rr_pick(input logic [N-1:0] v, input int p);
    logic [N-1:0] g;
    g = '0;
    for (int k = N-1; k >= 0; k--) begin
      if (v[(p + k) % N]) begin
        g = '0;
        g[(p + k) % N] = 1'b1;
      end
    end
    return g;
  endfunction

  // Reference model and scoreboard
  int           m_ptr;
  cdb_t         sb_q[$];
  cdb_t         m_last;
  cdb_t         m_exp;
  cdb_t         m_nxt;
  logic         m_busy;
  logic [N-1:0] m_ack;
  logic [N-1:0] ack_seen;

  always @(negedge clk) begin
    if (rst) begin
      check("rst_ack", 64'(req_ack), 64'd0);
      check("rst_cdb_vld", 64'(cdb_r.vld), 64'd0);
      check("rst_busy", 64'(busy_r), 64'd0);
      sb_q.delete();
      sb_q.push_back('0);
      m_ptr    = 0;
      m_last   = '0;
      m_busy   = 1'b0;
      ack_seen = '0;
    end else begin
      if (sb_q.size() == 0) begin
        check("sb_empty", 64'd1, 64'd0);
        m_exp = m_last;
      end else begin
        m_exp = sb_q.pop_front();
        check("cdb", 64'(cdb_r), 64'(m_exp));
      end
      check("busy", 64'(busy_r), 64'(m_busy));
      m_busy = m_exp.vld;
      m_ack  = rr_pick(req_vld, m_ptr);
      check("ack", 64'(req_ack), 64'(m_ack));
      ack_seen = req_ack;
      m_nxt     = m_last;
      m_nxt.vld = 1'b0;
      for (int j = 0; j < N; j++) begin
        if (m_ack[j]) begin
          m_nxt.vld   = 1'b1;
          m_nxt.tag   = req_tag[j*TW +: TW];
          m_nxt.wdata = req_wdata[j*WW +: WW];
          m_ptr       = (j + 1) % N;
        end
      end
      m_last = m_nxt;
      sb_q.push_back(m_nxt);
    end
  end

  typedef struct {
    logic [N-1:0] vld;
    logic [N-1:0] ack;
  } vec_t;

  vec_t tbl[19];

  initial begin
    // ptr=0 at entry: full round, drain, starvation guard, idle gaps
    tbl[0]  = '{5'b11111, 5'b00001};
    tbl[1]  = '{5'b11111, 5'b00010};
    tbl[2]  = '{5'b11111, 5'b00100};
    tbl[3]  = '{5'b11111, 5'b01000};
    tbl[4]  = '{5'b11111, 5'b10000};
    tbl[5]  = '{5'b11111, 5'b00001};
    tbl[6]  = '{5'b11110, 5'b00010};
    tbl[7]  = '{5'b11100, 5'b00100};
    tbl[8]  = '{5'b11000, 5'b01000};
    tbl[9]  = '{5'b10000, 5'b10000};
    tbl[10] = '{5'b01001, 5'b00001};
    tbl[11] = '{5'b01001, 5'b01000};
    tbl[12] = '{5'b00001, 5'b00001};
    tbl[13] = '{5'b00000, 5'b00000};
    tbl[14] = '{5'b00000, 5'b00000};
    tbl[15] = '{5'b00100, 5'b00100};
    tbl[16] = '{5'b00000, 5'b00000};
    tbl[17] = '{5'b00010, 5'b00010};
    tbl[18] = '{5'b00000, 5'b00000};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Single request from the multiplier, pointer wraps to 0
    @(posedge clk); #1;
    req_vld = 5'b10000;
    req_tag[4*TW +: TW]   = 3'd3;
    req_wdata[4*WW +: WW] = 32'hDEAD_BEEF;
    @(negedge clk);
    check("t2_ack", 64'(req_ack), 64'(5'b10000));
    @(posedge clk); #1;
    req_vld = '0;
    @(negedge clk);
    check("t2_cdb", 64'(cdb_r), 64'({1'b1, 3'd3, 32'hDEAD_BEEF}));
    @(posedge clk); #1;
    @(negedge clk);
    check("t2_idle_vld", 64'(cdb_r.vld), 64'd0);
    check("t2_hold", 64'({cdb_r.tag, cdb_r.wdata}), 64'({3'd3, 32'hDEAD_BEEF}));

    for (int i = 0; i < N; i++) begin
      req_tag[i*TW +: TW]   = TW'(i);
      req_wdata[i*WW +: WW] = 32'hC0DE_0000 | 32'(i);
    end
    for (int r = 0; r < 19; r++) begin
      @(posedge clk); #1;
      req_vld = tbl[r].vld;
      @(negedge clk);
      check($sformatf("tbl%0d_ack", r), 64'(req_ack), 64'(tbl[r].ack));
    end

    // Reset in the middle of traffic with every unit requesting
    @(posedge clk); #1;
    req_vld = 5'b11111;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("t1_ack_in_rst", 64'(req_ack), 64'd0);
    check("t1_cdb_in_rst", 64'(cdb_r.vld), 64'd0);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("t1_first_grant", 64'(req_ack), 64'(5'b00001));

    // Random traffic obeying the hold-until-ack rule
    for (int c = 0; c < 10000; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        if (req_vld[i] && ack_seen[i]) req_vld[i] = 1'b0;
        if (!req_vld[i] && ($urandom_range(0, 2) != 0)) begin
          req_vld[i]            = 1'b1;
          req_tag[i*TW +: TW]   = TW'($urandom);
          req_wdata[i*WW +: WW] = $urandom;
        end
      end
    end
    for (int c = 0; c < 3 * N; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        if (req_vld[i] && ack_seen[i]) req_vld[i] = 1'b0;
      end
    end
    @(negedge clk);
    check("drained", 64'(req_vld), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    @(posedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
